// File: rtl/align_batch_ctrl.sv
// align_batch_ctrl: buffers a batch of sign-magnitude partial products, streams them through a shared
// alignment unit against the batch max exponent and returns the accumulated sum. Option: ALIGN_SAT_EN.
module align_batch_ctrl #(
  parameter int unsigned N_PP  = 4,
  parameter int unsigned EXP_W = 5,
  parameter int unsigned PP_W  = 5,
  parameter int unsigned AL_W  = 16,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [PP_W-1:0]  in_pp,
  input  logic             in_last,
  output logic [EXP_W-1:0] aln_exp,
  output logic [EXP_W-1:0] aln_exp_max,
  output logic [PP_W-1:0]  aln_pp,
  input  logic [AL_W-1:0]  aln_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [EXP_W-1:0] out_exp_max,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(N_PP + 1);
  localparam int unsigned IDX_W = (N_PP > 1) ? $clog2(N_PP) : 1;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {LOAD, ALIGN, DONE} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   count_q, idx_q;
  logic [EXP_W-1:0]   exp_max_q, exp_max_nxt_c;
  logic [ACC_W-1:0]   acc_q, acc_nxt_c, addend_c;
  logic               aln_vld_q;
  logic [EXP_W-1:0]   exp_buf_q [DEPTH];
  logic [PP_W-1:0]    pp_buf_q  [DEPTH];

  logic accept_c, last_beat_c, issue_c, align_end_c, out_hs_c, neg_zero_c;

  assign accept_c    = (state_q == LOAD) && in_valid;
  assign last_beat_c = accept_c && (in_last || (count_q == CNT_W'(N_PP - 1)));
  assign issue_c     = (state_q == ALIGN) && (idx_q < count_q);
  assign align_end_c = (state_q == ALIGN) && aln_vld_q && (idx_q == count_q);
  assign out_hs_c    = (state_q == DONE) && out_valid && out_ready;

  assign exp_max_nxt_c = ((count_q == '0) || (in_exp > exp_max_q)) ? in_exp : exp_max_q;

  // Negative zero from the alignment unit contributes nothing.
  assign neg_zero_c = (aln_result == {1'b1, {(AL_W-1){1'b0}}});
  assign addend_c   = neg_zero_c ? '0 : ACC_W'($signed(aln_result));

`ifdef ALIGN_SAT_EN
  logic             sat_q, ovf_c;
  logic [ACC_W:0]   sum_ext_c;

  assign sum_ext_c = {acc_q[ACC_W-1], acc_q} + {addend_c[ACC_W-1], addend_c};
  assign ovf_c     = (sum_ext_c[ACC_W] != sum_ext_c[ACC_W-1]);

  // Once clamped, the accumulator holds its bound until the batch is consumed.
  always_comb begin
    acc_nxt_c = sum_ext_c[ACC_W-1:0];
    if (sat_q) begin
      acc_nxt_c = acc_q;
    end else if (ovf_c) begin
      acc_nxt_c = sum_ext_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else if (out_hs_c) begin
      sat_q <= 1'b0;
    end else if (aln_vld_q) begin
      sat_q <= sat_q | ovf_c;
    end
  end
`else
  assign acc_nxt_c = acc_q + addend_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      LOAD:    if (last_beat_c) state_nxt = ALIGN;
      ALIGN:   if (align_end_c) state_nxt = DONE;
      DONE:    if (out_hs_c)    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      idx_q       <= '0;
      exp_max_q   <= '0;
      acc_q       <= '0;
      aln_vld_q   <= 1'b0;
      aln_exp     <= '0;
      aln_exp_max <= '0;
      aln_pp      <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        exp_buf_q[i] <= '0;
        pp_buf_q[i]  <= '0;
      end
    end else begin
      if (accept_c) begin
        exp_buf_q[count_q[IDX_W-1:0]] <= in_exp;
        pp_buf_q[count_q[IDX_W-1:0]]  <= in_pp;
        count_q                       <= count_q + CNT_W'(1);
        exp_max_q                     <= exp_max_nxt_c;
      end

      // One entry presented per cycle; its aligned value is summed on the following edge.
      aln_vld_q   <= issue_c;
      aln_exp     <= '0;
      aln_exp_max <= '0;
      aln_pp      <= '0;
      if (issue_c) begin
        aln_exp     <= exp_buf_q[idx_q[IDX_W-1:0]];
        aln_pp      <= pp_buf_q[idx_q[IDX_W-1:0]];
        aln_exp_max <= exp_max_q;
        idx_q       <= idx_q + CNT_W'(1);
      end

      if (aln_vld_q) acc_q <= acc_nxt_c;

      if (out_hs_c) begin
        count_q   <= '0;
        idx_q     <= '0;
        exp_max_q <= '0;
        acc_q     <= '0;
      end

      in_ready  <= (state_nxt == LOAD);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != LOAD);
    end
  end

  assign out_sum     = acc_q;
  assign out_exp_max = exp_max_q;

endmodule
